// File: rtl/register_bank_pg.sv
// register_bank_pg
//
// Bank of NUM_REGS registers, each WIDTH bits wide.
// - One valid/ready write port with per-lane byte masks.
// - NUM_RD independent registered read ports. Each read port bypasses the
//   write that happens in the same cycle.
// - A clear sequencer sweeps the bank back to RESET_VAL, one register per
//   cycle.
// - All register contents are also exposed in parallel on q.
//
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   wr_valid/wr_ready          write handshake (accepted when both are high)
//   wr_addr/wr_data/wr_mask    write index, data, lane enables
//   wr_err                     one-cycle pulse after an accepted out-of-range write
//   rd_en/rd_addr              per-port read strobe and index (packed per port)
//   rd_data/rd_valid           per-port registered read data and valid
//   clr_req                    start a clear sweep (sampled in IDLE only)
//   busy                       high during every cycle of a clear sweep
//   q                          packed current contents of every register
module register_bank_pg #(
    parameter int              NUM_REGS  = 16,
    parameter int              WIDTH     = 32,
    parameter int              LANE_W    = 8,
    parameter int              NUM_RD    = 2,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    localparam int             AW        = $clog2(NUM_REGS),
    localparam int             NL        = WIDTH / LANE_W
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_valid,
    output logic                       wr_ready,
    input  logic [AW-1:0]              wr_addr,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic [NL-1:0]              wr_mask,
    output logic                       wr_err,
    input  logic [NUM_RD-1:0]          rd_en,
    input  logic [NUM_RD*AW-1:0]       rd_addr,
    output logic [NUM_RD*WIDTH-1:0]    rd_data,
    output logic [NUM_RD-1:0]          rd_valid,
    input  logic                       clr_req,
    output logic                       busy,
    output logic [NUM_REGS*WIDTH-1:0]  q
);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_e;

    localparam logic [AW:0]   NUM_REGS_W = (AW+1)'(NUM_REGS);
    localparam logic [AW-1:0] LAST_IDX   = AW'(NUM_REGS - 1);

    state_e            state_q, state_d;
    logic [AW-1:0]     clr_idx_q, clr_idx_d;
    logic              clr_active;

    logic [WIDTH-1:0]  regs_q [NUM_REGS];
    logic [WIDTH-1:0]  regs_d [NUM_REGS];

    logic              wr_fire;
    logic              wr_in_range;
    logic [WIDTH-1:0]  wr_old;
    logic [WIDTH-1:0]  wr_merged;
    logic              wr_err_q;

    // ------------------------------------------------------------------
    // Clear sequencer FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            clr_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_idx_q <= clr_idx_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        case (state_q)
            ST_IDLE: begin
                clr_idx_d = '0;
                if (clr_req) begin
                    state_d = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                if (clr_idx_q == LAST_IDX) begin
                    state_d   = ST_IDLE;
                    clr_idx_d = '0;
                end else begin
                    clr_idx_d = clr_idx_q + 1'b1;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                clr_idx_d = '0;
            end
        endcase
    end

    // Output logic. A clear request wins over a write in the same cycle,
    // so wr_ready drops as soon as clr_req is seen in IDLE.
    always_comb begin
        wr_ready   = 1'b0;
        busy       = 1'b0;
        clr_active = 1'b0;
        case (state_q)
            ST_IDLE: begin
                wr_ready = !clr_req;
            end
            ST_CLEAR: begin
                busy       = 1'b1;
                clr_active = 1'b1;
            end
            default: begin
                wr_ready = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Write path
    // ------------------------------------------------------------------
    assign wr_fire     = wr_valid && wr_ready;
    assign wr_in_range = ({1'b0, wr_addr} < NUM_REGS_W);

    // Current contents of the target register. An index that is out of
    // range matches no register and therefore reads as 0. That value is
    // never stored.
    always_comb begin
        wr_old = '0;
        for (int r = 0; r < NUM_REGS; r++) begin
            if (wr_addr == AW'(r)) begin
                wr_old = regs_q[r];
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NL; gi++) begin : g_lane
            assign wr_merged[gi*LANE_W +: LANE_W] = wr_mask[gi] ? wr_data[gi*LANE_W +: LANE_W]
                                                                : wr_old[gi*LANE_W +: LANE_W];
        end
    endgenerate

    // Next contents of the whole bank.
    // - During a sweep, only the clear slot changes; writes are blocked by
    //   wr_ready.
    // - Read ports look at regs_d, which gives them write-to-read bypass
    //   without any extra compare logic.
    always_comb begin
        for (int r = 0; r < NUM_REGS; r++) begin
            regs_d[r] = regs_q[r];
            if (clr_active && (clr_idx_q == AW'(r))) begin
                regs_d[r] = RESET_VAL;
            end else if (wr_fire && wr_in_range && (wr_addr == AW'(r))) begin
                regs_d[r] = wr_merged;
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int r = 0; r < NUM_REGS; r++) begin
            regs_q[r] <= rst ? RESET_VAL : regs_d[r];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_err_q <= 1'b0;
        end else begin
            wr_err_q <= wr_fire && !wr_in_range;
        end
    end

    assign wr_err = wr_err_q;

    generate
        for (gi = 0; gi < NUM_REGS; gi++) begin : g_q
            assign q[gi*WIDTH +: WIDTH] = regs_q[gi];
        end
    endgenerate

    // ------------------------------------------------------------------
    // Read ports
    // ------------------------------------------------------------------
    generate
        for (gi = 0; gi < NUM_RD; gi++) begin : g_rd
            logic [AW-1:0]    addr;
            logic [WIDTH-1:0] rd_val;
            logic [WIDTH-1:0] rd_data_q;
            logic             rd_valid_q;

            assign addr = rd_addr[gi*AW +: AW];

            // Out-of-range index matches nothing and returns 0
            always_comb begin
                rd_val = '0;
                for (int r = 0; r < NUM_REGS; r++) begin
                    if (addr == AW'(r)) begin
                        rd_val = regs_d[r];
                    end
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    rd_data_q  <= '0;
                    rd_valid_q <= 1'b0;
                end else begin
                    rd_valid_q <= rd_en[gi];
                    if (rd_en[gi]) begin
                        rd_data_q <= rd_val;
                    end
                end
            end

            assign rd_data[gi*WIDTH +: WIDTH] = rd_data_q;
            assign rd_valid[gi]               = rd_valid_q;
        end
    endgenerate

endmodule

// File: tb/tb_register_bank_pg.sv
module tb_register_bank_pg;

    localparam logic [31:0] RV = 32'hDEAD_BEEF;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_valid;
    logic [3:0]  wr_addr;
    logic [31:0] wr_data;
    logic [3:0]  wr_mask;
    logic [1:0]  rd_en;
    logic [7:0]  rd_addr;
    logic        clr_req;

    // main instance: 16 registers, non-zero reset value
    logic        wr_ready, wr_err, busy;
    logic [63:0] rd_data;
    logic [1:0]  rd_valid;
    logic [511:0] q;

    // small instance: 12 registers, exercises out-of-range indices
    logic        s_wr_ready, s_wr_err, s_busy;
    logic [63:0] s_rd_data;
    logic [1:0]  s_rd_valid;
    logic [383:0] s_q;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    register_bank_pg #(
        .NUM_REGS(16), .WIDTH(32), .LANE_W(8), .NUM_RD(2), .RESET_VAL(RV)
    ) dut (
        .clk(clk), .rst(rst),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr),
        .wr_data(wr_data), .wr_mask(wr_mask), .wr_err(wr_err),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
        .clr_req(clr_req), .busy(busy), .q(q)
    );

    register_bank_pg #(
        .NUM_REGS(12), .WIDTH(32), .LANE_W(8), .NUM_RD(2), .RESET_VAL(32'h0)
    ) dut_small (
        .clk(clk), .rst(rst),
        .wr_valid(wr_valid), .wr_ready(s_wr_ready), .wr_addr(wr_addr),
        .wr_data(wr_data), .wr_mask(wr_mask), .wr_err(s_wr_err),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(s_rd_data), .rd_valid(s_rd_valid),
        .clr_req(clr_req), .busy(s_busy), .q(s_q)
    );

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end else begin
            $display("ok   %s: %h", tag, obs);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] m);
        wr_valid = 1'b1;
        wr_addr  = a;
        wr_data  = d;
        wr_mask  = m;
        tick();
        wr_valid = 1'b0;
        $display("write addr %0d data %h mask %b", a, d, m);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stim
        logic [31:0] s_model [12];
        int          n;

        rst = 1'b1; wr_valid = 1'b0; wr_addr = '0; wr_data = '0; wr_mask = '0;
        rd_en = '0; rd_addr = '0; clr_req = 1'b0;
        for (int r = 0; r < 12; r++) s_model[r] = 32'h0;
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_wr_ready", wr_ready, 1'b1);
        check_eq("rst_wr_err", wr_err, 1'b0);
        check_eq("rst_rd_valid", rd_valid, 2'b00);
        check_eq("rst_rd_data", rd_data, 64'h0);
        for (int r = 0; r < 16; r++) check_eq($sformatf("rst_q%0d", r), q[r*32 +: 32], RV);

        // Dual read of addr 3 after reset
        rd_en = 2'b11; rd_addr = {4'd3, 4'd3};
        tick();
        rd_en = 2'b00;
        check_eq("rd3_valid", rd_valid, 2'b11);
        check_eq("rd3_p0", rd_data[31:0], RV);
        check_eq("rd3_p1", rd_data[63:32], RV);

        // Masked writes to addr 5
        do_write(4'd5, 32'hAABB_CCDD, 4'b1111);
        check_eq("w5_full", q[5*32 +: 32], 32'hAABB_CCDD);
        do_write(4'd5, 32'h1122_3344, 4'b0101);
        check_eq("w5_masked", q[5*32 +: 32], 32'hAA22_CC44);
        do_write(4'd5, 32'hFFFF_FFFF, 4'b0000);
        check_eq("w5_mask0", q[5*32 +: 32], 32'hAA22_CC44);
        s_model[5] = 32'hAA22_CC44;
        rd_en = 2'b01; rd_addr = {4'd0, 4'd5};
        tick();
        rd_en = 2'b00;
        check_eq("rd5_valid", rd_valid, 2'b01);
        check_eq("rd5_p0", rd_data[31:0], 32'hAA22_CC44);

        // Write to addr 2 with both ports reading addr 2 in the same cycle
        wr_valid = 1'b1; wr_addr = 4'd2; wr_data = 32'h0000_00FF; wr_mask = 4'b1111;
        rd_en = 2'b11; rd_addr = {4'd2, 4'd2};
        tick();
        wr_valid = 1'b0; rd_en = 2'b00;
        s_model[2] = 32'h0000_00FF;
        check_eq("byp_valid", rd_valid, 2'b11);
        check_eq("byp_p0", rd_data[31:0], 32'h0000_00FF);
        check_eq("byp_p1", rd_data[63:32], 32'h0000_00FF);
        tick();
        check_eq("idle_valid", rd_valid, 2'b00);
        check_eq("hold_p0", rd_data[31:0], 32'h0000_00FF);

        // Out-of-range write on the 12-register bank
        check_eq("oor_ready", s_wr_ready, 1'b1);
        do_write(4'd14, 32'h1234_5678, 4'b1111);
        check_eq("oor_err", s_wr_err, 1'b1);
        check_eq("inrange_no_err", wr_err, 1'b0);
        for (int r = 0; r < 12; r++) check_eq($sformatf("oor_q%0d", r), s_q[r*32 +: 32], s_model[r]);
        rd_en = 2'b01; rd_addr = {4'd0, 4'd13};
        tick();
        rd_en = 2'b00;
        check_eq("oor_err_pulse", s_wr_err, 1'b0);
        check_eq("oor_rd_valid", s_rd_valid, 2'b01);
        check_eq("oor_rd_data", s_rd_data[31:0], 32'h0);

        // Clear sweep
        for (int r = 0; r < 16; r++) do_write(4'(r), 32'h5A5A_5A5A, 4'b1111);
        check_eq("fill_q15", q[15*32 +: 32], 32'h5A5A_5A5A);
        clr_req = 1'b1; wr_valid = 1'b1; wr_addr = 4'd7; wr_data = 32'h1111_1111; wr_mask = 4'b1111;
        #1;
        check_eq("clr_blocks_ready", wr_ready, 1'b0);
        tick();
        clr_req = 1'b0;
        check_eq("clr_busy_start", busy, 1'b1);
        n = 0;
        while (busy && n < 40) begin
            check_eq($sformatf("clr_ready_%0d", n), wr_ready, 1'b0);
            if (n == 0) begin
                rd_en = 2'b11; rd_addr = {4'd0, 4'd0};
            end else begin
                rd_en = 2'b00;
            end
            tick();
            n++;
            if (n == 1) begin
                check_eq("clr_rd0_valid", rd_valid, 2'b11);
                check_eq("clr_rd0_p0", rd_data[31:0], RV);
                check_eq("clr_rd0_p1", rd_data[63:32], RV);
            end
            if (n == 5) check_eq("clr_mid_q15", q[15*32 +: 32], 32'h5A5A_5A5A);
        end
        wr_valid = 1'b0;
        rd_en = 2'b00;
        check_eq("clr_busy_cycles", n, 16);
        check_eq("clr_end_ready", wr_ready, 1'b1);
        for (int r = 0; r < 16; r++) check_eq($sformatf("clr_q%0d", r), q[r*32 +: 32], RV);

        // Reset in the middle of a sweep
        do_write(4'd10, 32'h5A5A_5A5A, 4'b1111);
        check_eq("pre_q10", q[10*32 +: 32], 32'h5A5A_5A5A);
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        tick();
        tick();
        tick();
        check_eq("mid_busy", busy, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("abort_busy", busy, 1'b0);
        check_eq("abort_ready", wr_ready, 1'b1);
        check_eq("abort_q10", q[10*32 +: 32], RV);
        check_eq("abort_rd_valid", rd_valid, 2'b00);

        // A fresh sweep after the abort runs its full length
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        n = 0;
        while (busy && n < 40) begin
            tick();
            n++;
        end
        check_eq("resweep_cycles", n, 16);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/register_bank_pg.md
# register_bank_pg

Parametrised successor to the single-write register array. It provides NUM_REGS registers of WIDTH bits with a valid/ready write port that supports per-lane write masks, plus NUM_RD independent registered read ports with write-to-read bypass. A multi-cycle clear sequencer sweeps the bank back to RESET_VAL on request. The block sits between a control/CSR master and datapath logic, which also consumes the full register contents in parallel through `q`.

## Interface
Parameters:
- NUM_REGS, 16, number of registers (≥2; need not be a power of 2)
- WIDTH, 32, register width in bits; must be a multiple of LANE_W
- LANE_W, 8, write-mask granularity in bits
- NUM_RD, 2, number of read ports (≥1)
- RESET_VAL, 0, WIDTH-bit value loaded by reset and by clear
- Derived: AW = $clog2(NUM_REGS), NL = WIDTH/LANE_W

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  synchronous active-high reset
- wr_valid  in  1  write request
- wr_ready  out  1  write accepted when wr_valid && wr_ready
- wr_addr  in  AW  write register index
- wr_data  in  WIDTH  write data
- wr_mask  in  NL  lane enables; bit i covers wr_data[i*LANE_W +: LANE_W]
- wr_err  out  1  one-cycle pulse: an accepted write had an out-of-range address
- rd_en  in  NUM_RD  per-port read strobe
- rd_addr  in  NUM_RD*AW  port p uses rd_addr[p*AW +: AW]
- rd_data  out  NUM_RD*WIDTH  port p drives rd_data[p*WIDTH +: WIDTH]
- rd_valid  out  NUM_RD  per-port read data valid
- clr_req  in  1  start a clear sweep (sampled in IDLE only)
- busy  out  1  high while clear sweep is in progress
- q  out  NUM_REGS*WIDTH  register r drives q[r*WIDTH +: WIDTH]; reflects current register contents

## Operation
- FSM states: IDLE and CLEAR.
  - IDLE → CLEAR when clr_req=1.
  - CLEAR → IDLE after index NUM_REGS-1 has been cleared.
- Write port: wr_ready = (state==IDLE) && !clr_req, so clear has priority over a same-cycle write.
- Accepted write with wr_addr < NUM_REGS: each lane with its mask bit set is updated from wr_data; unmasked lanes hold. wr_mask=0 is accepted and changes nothing.
- Accepted write with wr_addr ≥ NUM_REGS: no register changes; wr_err=1 on the next cycle.
- CLEAR: a counter clr_idx starts at 0 and writes RESET_VAL to reg[clr_idx], one register per cycle. busy=1 in every CLEAR cycle. clr_req is ignored while in CLEAR.
- Reads, per port, independently:
  - When rd_en[p]=1, rd_data[p] is loaded with reg[rd_addr[p]] and rd_valid[p]=1 on the next cycle.
  - When rd_en[p]=0, rd_valid[p]=0 and rd_data[p] holds its last value.
  - Out-of-range read returns 0 with rd_valid still asserted.
- Bypass: if a read address equals the address being updated in the same cycle (accepted write or clr_idx), the read returns the post-update value: the merged lanes, or RESET_VAL.
- Multiple read ports may address the same register in the same cycle.

## Timing
- Reset (rst=1 at a rising edge) loads every register with RESET_VAL and forces state=IDLE and clr_idx=0.
- Output values after reset: q = RESET_VAL in every slot, rd_data=0, rd_valid=0, wr_err=0, busy=0, wr_ready=1 (while clr_req=0).
- Reset asserted mid-CLEAR aborts the sweep; all registers are reset in that same cycle.
- Write latency: q shows the new value 1 cycle after acceptance.
- Read latency: 1 cycle from rd_en to rd_valid/rd_data.
- Clear duration: busy is high for exactly NUM_REGS cycles, starting the cycle after clr_req is sampled. wr_ready returns to 1 on the cycle busy falls.
- wr_valid held with wr_ready=0 is not accepted; the master keeps wr_addr, wr_data and wr_mask stable until acceptance.
- No combinational path from rd_* inputs to outputs. wr_ready depends combinationally on clr_req and state only.

## Test plan
- Reset then full dump: after rst, q shows every slot = RESET_VAL. Both ports read addr 3 → rd_valid=2'b11 one cycle later, rd_data=RESET_VAL.
- Masked write: write addr 5 data 0xAABBCCDD mask 4'b1111, then data 0x11223344 mask 4'b0101 → reg5 = 0xAA22CC44 in q and via a read.
- Bypass and dual read: write addr 2 = 0x0000_00FF while port0 reads 2 and port1 reads 2 in the same cycle → both ports return 0x0000_00FF next cycle.
- Out-of-range (NUM_REGS=12): write addr 14 → handshake completes, wr_err pulses 1 cycle, q unchanged. Read addr 13 → 0 with rd_valid=1.
- Clear sweep: fill all regs with 0x5A5A5A5A, pulse clr_req together with wr_valid → write not accepted; busy high for 16 cycles, wr_ready=0 throughout; afterwards all q = RESET_VAL. A read of addr 0 mid-sweep returns RESET_VAL.
- Reset mid-clear: assert rst on sweep cycle 4 → next cycle busy=0, state IDLE, all regs = RESET_VAL, wr_ready=1.
